// File: rtl/alarma_ctrl.sv
// rtl/alarma_ctrl.sv - thermal alarm FSM with heater/fan enables and latched alarms (option: ALARMA_EVENT_COUNT_EN)
module alarma_ctrl #(
    parameter int M  = 4,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          es_bajo,
    input  logic          es_alto,
    input  logic          per_bajo,
    input  logic          per_alto,
    input  logic          ack,
    output logic [1:0]    estado,
    output logic          calefactor_on,
    output logic          ventilador_on,
    output logic          alarma_frio,
    output logic          alarma_calor,
    output logic          pendiente_ack,
    output logic [EW-1:0] n_ev_frio,
    output logic [EW-1:0] n_ev_calor
);

    localparam int CW = (M < 2) ? 1 : $clog2(M + 1);

    localparam logic [1:0] S_NORMAL   = 2'd0;
    localparam logic [1:0] S_FRIO     = 2'd1;
    localparam logic [1:0] S_CALOR    = 2'd2;
    localparam logic [1:0] S_RECUPERA = 2'd3;

    localparam logic [CW-1:0] REC_LAST = CW'(M - 1);
    localparam logic [CW-1:0] REC_ONE  = CW'(1);

    logic [1:0]    estado_q, estado_d;
    logic [CW-1:0] cont_rec_q, cont_rec_d;
    logic          calefactor_q, ventilador_q;
    logic          alarma_frio_q, alarma_frio_d;
    logic          alarma_calor_q, alarma_calor_d;
    logic          in_rango;
    logic          enter_frio, enter_calor;

    assign in_rango = !es_bajo && !es_alto;

    // Next-state and recovery counter; per_alto always outranks per_bajo
    always_comb begin
        estado_d   = estado_q;
        cont_rec_d = cont_rec_q;
        case (estado_q)
            S_NORMAL: begin
                if (per_alto)      estado_d = S_CALOR;
                else if (per_bajo) estado_d = S_FRIO;
            end
            S_FRIO: begin
                if (per_alto) begin
                    estado_d = S_CALOR;
                end else if (in_rango) begin
                    estado_d   = S_RECUPERA;
                    cont_rec_d = '0;
                end
            end
            S_CALOR: begin
                if (per_bajo && !per_alto) begin
                    estado_d = S_FRIO;
                end else if (in_rango) begin
                    estado_d   = S_RECUPERA;
                    cont_rec_d = '0;
                end
            end
            default: begin
                if (per_alto) begin
                    estado_d = S_CALOR;
                end else if (per_bajo) begin
                    estado_d = S_FRIO;
                end else if (!in_rango) begin
                    cont_rec_d = '0;
                end else if (cont_rec_q == REC_LAST) begin
                    estado_d   = S_NORMAL;
                    cont_rec_d = '0;
                end else begin
                    cont_rec_d = cont_rec_q + REC_ONE;
                end
            end
        endcase
    end

    assign enter_frio  = (estado_d == S_FRIO)  && (estado_q != S_FRIO);
    assign enter_calor = (estado_d == S_CALOR) && (estado_q != S_CALOR);

    // Alarm latches: entering the state sets (and wins over ack); ack clears only once the state is left
    always_comb begin
        alarma_frio_d  = alarma_frio_q;
        alarma_calor_d = alarma_calor_q;
        if (enter_frio)                        alarma_frio_d  = 1'b1;
        else if (ack && estado_d != S_FRIO)    alarma_frio_d  = 1'b0;
        if (enter_calor)                       alarma_calor_d = 1'b1;
        else if (ack && estado_d != S_CALOR)   alarma_calor_d = 1'b0;
    end

    // State, counter, actuator and alarm registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado_q       <= S_NORMAL;
            cont_rec_q     <= '0;
            calefactor_q   <= 1'b0;
            ventilador_q   <= 1'b0;
            alarma_frio_q  <= 1'b0;
            alarma_calor_q <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            cont_rec_q     <= cont_rec_d;
            calefactor_q   <= (estado_d == S_FRIO);
            ventilador_q   <= (estado_d == S_CALOR);
            alarma_frio_q  <= alarma_frio_d;
            alarma_calor_q <= alarma_calor_d;
        end
    end

`ifdef ALARMA_EVENT_COUNT_EN
    logic [EW-1:0] ev_frio_q, ev_calor_q;

    // Saturating entry counters, cleared only by reset
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ev_frio_q  <= '0;
            ev_calor_q <= '0;
        end else begin
            if (enter_frio && ev_frio_q != {EW{1'b1}})
                ev_frio_q <= ev_frio_q + {{(EW-1){1'b0}}, 1'b1};
            if (enter_calor && ev_calor_q != {EW{1'b1}})
                ev_calor_q <= ev_calor_q + {{(EW-1){1'b0}}, 1'b1};
        end
    end

    assign n_ev_frio  = ev_frio_q;
    assign n_ev_calor = ev_calor_q;
`else
    assign n_ev_frio  = '0;
    assign n_ev_calor = '0;
`endif

    assign estado        = estado_q;
    assign calefactor_on = calefactor_q;
    assign ventilador_on = ventilador_q;
    assign alarma_frio   = alarma_frio_q;
    assign alarma_calor  = alarma_calor_q;
    assign pendiente_ack = alarma_frio_q | alarma_calor_q;

endmodule
